// File: rtl/mod_del_ctrl_pkg.sv
// mod_del_ctrl_pkg: shared dsp types and constants for the modulated delay controller
package mod_del_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  localparam int MIN_DEL = 1;
endpackage

// File: rtl/mod_del_ctrl_step_div.sv
// step_div: counts sample strobes and fires a tick every max(rate,1) samples
module step_div #(
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_i,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic                  clear,
  output logic                  tick
);
  logic [RATE_WIDTH-1:0] cnt, lim;
  always_comb begin
    lim  = (rate == '0) ? '0 : rate - 1'b1;
    tick = vld_i && !clear && cnt == lim;
  end
  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else if (vld_i) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mod_del_ctrl.sv
// mod_del_ctrl: triangle-LFO delay modulator with pending-config handshake
module mod_del_ctrl
  import mod_del_ctrl_pkg::*;
#(
  parameter int DEL_WIDTH  = 9,
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  vld_i,
  input  logic [DEL_WIDTH-1:0]  cfg_base,
  input  logic [DEL_WIDTH-1:0]  cfg_depth,
  input  logic [RATE_WIDTH-1:0] cfg_rate,
  input  logic                  cfg_vld,
  output logic                  cfg_rdy,
  output logic [DEL_WIDTH-1:0]  del_o,
  output logic                  turn_o
);
  localparam logic [DEL_WIDTH-1:0] DEL_MIN = DEL_WIDTH'(MIN_DEL);
  state_t                state;
  logic [DEL_WIDTH-1:0]  off, base_a, depth_a, base_p, depth_p, del_n;
  logic [RATE_WIDTH-1:0] rate_a, rate_p;
  logic [DEL_WIDTH:0]    sum;
  logic                  pend, tick, clear, apply;
  step_div #(.RATE_WIDTH(RATE_WIDTH)) u_div (
    .clk   (clk),
    .rst   (rst),
    .vld_i (vld_i),
    .rate  (rate_a),
    .clear (clear),
    .tick  (tick)
  );
  assign cfg_rdy = !pend;
  // new config lands only where offset is 0, so offset never exceeds active depth
  always_comb begin
    clear = state == IDLE || !en;
    apply = pend && (state == IDLE || (tick && (state == UP ? depth_a == '0 : off == DEL_WIDTH'(1))));
    sum   = {1'b0, base_a} + {1'b0, off};
    del_n = sum[DEL_WIDTH] ? '1 : (sum[DEL_WIDTH-1:0] < DEL_MIN ? DEL_MIN : sum[DEL_WIDTH-1:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      off     <= '0;
      pend    <= 1'b0;
      base_p  <= '0;
      depth_p <= '0;
      rate_p  <= '0;
      base_a  <= DEL_MIN;
      depth_a <= '0;
      rate_a  <= RATE_WIDTH'(1);
      del_o   <= DEL_MIN;
      turn_o  <= 1'b0;
    end else begin
      turn_o <= 1'b0;
      del_o  <= del_n;
      if (cfg_vld && !pend) begin
        pend    <= 1'b1;
        base_p  <= cfg_base;
        depth_p <= cfg_depth;
        rate_p  <= cfg_rate;
      end
      if (apply) begin
        pend    <= 1'b0;
        base_a  <= base_p;
        depth_a <= depth_p;
        rate_a  <= rate_p;
      end
      if (state == IDLE) begin
        off <= '0;
        if (en) state <= UP;
      end else if (!en) begin
        state <= IDLE;
        off   <= '0;
      end else if (tick) begin
        if (state == UP) begin
          if (depth_a != '0) begin
            off <= off + 1'b1;
            if (off + 1'b1 == depth_a) begin
              state  <= DOWN;
              turn_o <= 1'b1;
            end
          end
        end else begin
          off <= off - 1'b1;
          if (off == DEL_WIDTH'(1)) begin
            state  <= UP;
            turn_o <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mod_del_ctrl.sv
// tb_mod_del_ctrl: randomized bench with a triangle-LFO reference model and directed literal checks
module tb_mod_del_ctrl;
  localparam int DW = 9, RW = 16, DMAX = (1 << DW) - 1;
  logic clk = 0, rst = 1, en = 0, vld_i = 0, cfg_vld = 0;
  logic [DW-1:0] cfg_base = '0, cfg_depth = '0;
  logic [RW-1:0] cfg_rate = '0;
  logic cfg_rdy, turn_o;
  logic [DW-1:0] del_o;
  mod_del_ctrl #(.DEL_WIDTH(DW), .RATE_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .en(en), .vld_i(vld_i), .cfg_base(cfg_base), .cfg_depth(cfg_depth),
    .cfg_rate(cfg_rate), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .del_o(del_o), .turn_o(turn_o)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference: running flag, signed direction, integer position, samples since last step
  bit running = 0, pend = 0, e_turn = 0;
  int dir = 1, pos = 0, samples = 0, e_del = 1;
  int a_base = 1, a_depth = 0, a_rate = 1, p_base = 0, p_depth = 0, p_rate = 0;
  task automatic model_step();
    int s, r;
    bit ap, cp, trn;
    if (rst) begin
      running = 0; dir = 1; pos = 0; samples = 0; pend = 0;
      a_base = 1; a_depth = 0; a_rate = 1; e_del = 1; e_turn = 0;
      return;
    end
    s = a_base + pos;
    e_del = s > DMAX ? DMAX : (s < 1 ? 1 : s);
    r = a_rate < 1 ? 1 : a_rate;
    ap = 0; trn = 0; cp = cfg_vld && !pend;
    if (!running) begin
      ap = pend; pos = 0; samples = 0; dir = 1; running = en;
    end else if (!en) begin
      running = 0; pos = 0; samples = 0;
    end else if (vld_i) begin
      if (samples + 1 < r) samples++;
      else begin
        samples = 0;
        if (a_depth == 0) ap = pend;
        else begin
          pos += dir;
          if (dir > 0 && pos == a_depth) begin dir = -1; trn = 1; end
          else if (dir < 0 && pos == 0) begin dir = 1; trn = 1; ap = pend; end
        end
      end
    end
    if (ap) begin a_base = p_base; a_depth = p_depth; a_rate = p_rate; pend = 0; end
    if (cp) begin pend = 1; p_base = cfg_base; p_depth = cfg_depth; p_rate = cfg_rate; end
    e_turn = trn;
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("del_o", del_o, e_del);
      chk("turn_o", turn_o, e_turn);
      chk("cfg_rdy", cfg_rdy, !pend);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_rst();
    rst = 1; en = 0; vld_i = 0; cfg_vld = 0;
    cyc(1);
    chk("rst_del", del_o, 1);
    chk("rst_rdy", cfg_rdy, 1);
    chk("rst_turn", turn_o, 0);
    rst = 0;
  endtask
  task automatic offer(input int b, input int d, input int r);
    cfg_base = DW'(b); cfg_depth = DW'(d); cfg_rate = RW'(r); cfg_vld = 1;
    cyc(1);
    cfg_vld = 0;
  endtask
  task automatic wait_del(input int v);
    int n = 0;
    while (del_o != DW'(v) && n < 200) begin cyc(1); n++; end
    chk("wait_del", del_o, v);
  endtask
  initial begin
    int rv[$], rl[$], exp_runs[8], idx, mx, mn, turns, n;
    exp_runs = '{10, 11, 12, 13, 12, 11, 10, 11};
    cyc(1);
    chk_on = 1;
    // fixed base, zero depth
    do_rst(); en = 1; vld_i = 1;
    offer(10, 0, 1); cyc(4);
    chk("base_only", del_o, 10);
    cyc(20);
    chk("base_hold", del_o, 10);
    // triangle ramp at rate 2
    do_rst(); en = 1; vld_i = 1;
    offer(10, 3, 2);
    turns = 0;
    repeat (40) begin
      cyc(1);
      turns += int'(turn_o);
      if (rl.size() > 0 && rv[$] == int'(del_o)) rl[$] = rl[$] + 1;
      else begin rv.push_back(int'(del_o)); rl.push_back(1); end
    end
    idx = 0;
    while (idx < rv.size() && rv[idx] != 10) idx++;
    for (int i = 0; i < 8; i++) chk("ramp_val", (idx + i < rv.size()) ? rv[idx + i] : -1, exp_runs[i]);
    for (int i = 1; i < 7; i++) chk("ramp_len", (idx + i < rl.size()) ? rl[idx + i] : -1, 2);
    chk("ramp_turns", int'(turns >= 2), 1);
    // shallower depth offered mid-ramp
    do_rst(); en = 1; vld_i = 1;
    offer(10, 3, 1); wait_del(12);
    offer(10, 1, 1);
    chk("pend_rdy", cfg_rdy, 0);
    n = 0;
    while (!cfg_rdy && n < 100) begin cyc(1); n++; end
    chk("rdy_back", cfg_rdy, 1);
    cyc(2);
    mx = 0; mn = DMAX;
    repeat (12) begin
      cyc(1);
      if (del_o > mx) mx = del_o;
      if (del_o < mn) mn = del_o;
    end
    chk("new_peak", mx, 11);
    chk("new_floor", mn, 10);
    // saturation and minimum clamp
    do_rst(); en = 1; vld_i = 1;
    offer(510, 5, 1);
    mx = 0;
    repeat (30) begin cyc(1); if (del_o > mx) mx = del_o; end
    chk("sat_max", mx, 511);
    do_rst(); en = 1; vld_i = 1;
    offer(0, 0, 1); cyc(4);
    chk("min_clamp", del_o, 1);
    // enable drop then reset mid-DOWN
    do_rst(); en = 1; vld_i = 1;
    offer(10, 3, 1); wait_del(12);
    en = 0; cyc(2);
    chk("en_drop", del_o, 10);
    en = 1; wait_del(13); wait_del(12);
    do_rst(); en = 1; vld_i = 1; cyc(10);
    chk("rst_cfg", del_o, 1);
    // random traffic
    do_rst();
    repeat (3000) begin
      rst = $urandom_range(0, 199) == 0;
      en = $urandom_range(0, 19) != 0;
      vld_i = $urandom_range(0, 2) != 0;
      cfg_vld = $urandom_range(0, 7) == 0;
      case ($urandom_range(0, 3))
        0: cfg_base = '0;
        1: cfg_base = DW'(1);
        2: cfg_base = DW'($urandom_range(0, 20));
        default: cfg_base = DW'($urandom_range(500, 511));
      endcase
      cfg_depth = DW'($urandom_range(0, 6));
      cfg_rate = RW'($urandom_range(0, 3));
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_del_ctrl.md
MOD_DEL_CTRL -- requirements
Module: mod_del_ctrl

Interface
REQ-001 SHALL have parameter DEL_WIDTH, default 9, giving the width of the delay value; it matches the delay-line address width (512 deep).
REQ-002 SHALL have parameter RATE_WIDTH, default 16, giving the width of the LFO step divider.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: modulation enable.
REQ-006 SHALL have port vld_i, input, 1 bit: audio sample strobe, the same strobe that feeds the delay line.
REQ-007 SHALL have port cfg_base, input, DEL_WIDTH: base delay in samples.
REQ-008 SHALL have port cfg_depth, input, DEL_WIDTH: peak modulation offset.
REQ-009 SHALL have port cfg_rate, input, RATE_WIDTH: samples per offset step.
REQ-010 SHALL have port cfg_vld, input, 1 bit: config offer.
REQ-011 SHALL have port cfg_rdy, output, 1 bit: config accept.
REQ-012 SHALL have port del_o, output, DEL_WIDTH: delay value driving the delay line's del input.
REQ-013 SHALL have port turn_o, output, 1 bit: one-cycle pulse at each LFO direction change.

Function
REQ-014 Config transfer SHALL occur on a cycle with cfg_vld=1 and cfg_rdy=1; the values are captured into a pending register.
REQ-015 cfg_rdy SHALL be 1 exactly when no pending config exists.
REQ-016 A pending config SHALL become active only at one of three points: in IDLE (the cycle after capture), at the DOWN->UP turnaround, or on any step tick while active depth=0. Pending then clears.
REQ-017 The step tick SHALL be driven by a divider counter that increments on each vld_i.
REQ-018 A tick SHALL fire on the vld_i where the divider count = max(rate,1)-1; the count then returns to 0.
REQ-019 cfg_rate=0 SHALL behave as 1, giving a step every sample.
REQ-020 The FSM SHALL have states IDLE, UP and DOWN.
REQ-021 IDLE: offset=0 and count=0; the FSM SHALL go to UP on the cycle after en=1.
REQ-022 UP: on each tick, offset SHALL increment; when the new offset = depth, the FSM SHALL go to DOWN and turn_o SHALL pulse.
REQ-023 DOWN: on each tick, offset SHALL decrement; when the new offset = 0, the FSM SHALL go to UP, turn_o SHALL pulse, and a pending config SHALL be applied.
REQ-024 With depth=0, the FSM SHALL stay in UP with offset 0 and turn_o SHALL never pulse.
REQ-025 A depth reduced below the current offset SHALL only ever be applied at offset 0, so offset never exceeds the active depth.
REQ-026 en=0 in UP or DOWN SHALL return the FSM to IDLE on the next cycle, clearing offset and count; a pending config is retained.
REQ-027 del_o SHALL be registered and equal to clamp(base+offset, 1, 2^DEL_WIDTH-1), computed with a DEL_WIDTH+1 bit sum.
REQ-028 del_o SHALL update 1 cycle after an offset or active-config change.
REQ-029 vld_i and cfg handshake in the same cycle: the tick SHALL be evaluated against the old active config; a config applied on that same tick SHALL take effect for the next tick.

Reset
REQ-030 rst SHALL force state IDLE, offset 0, count 0 and pending cleared.
REQ-031 rst SHALL set the active config to base 1, depth 0, rate 1.
REQ-032 rst SHALL set del_o=1, turn_o=0 and cfg_rdy=1 on the cycle after rst is asserted.
REQ-033 rst SHALL override all other inputs, including rst asserted mid-ramp.

Structure
REQ-034 A shared dsp package SHALL hold the FSM state enum and the minimum-delay constant (1).
REQ-035 The divider SHALL be a sub-module, step_div (vld_i, rate, clear -> tick).

Verification
REQ-036 Reset, then cfg base=10, depth=0, en=1, with vld_i every cycle -> del_o=10 and remains 10; turn_o stays 0.
REQ-037 base=10, depth=3, rate=2, vld_i continuous -> del_o follows 10,11,12,13,12,11,10,11 with each value held 2 samples; turn_o pulses on reaching 13 and 10.
REQ-038 Mid-ramp at offset 2, offer depth=1 -> cfg_rdy drops and del_o continues up to depth 3 and back down. At the offset-0 turnaround the new config applies and the peak becomes 11; cfg_rdy returns to 1.
REQ-039 base=510, depth=5 -> del_o saturates at 511; base=0, depth=0 -> del_o=1.
REQ-040 Drop en at offset 2 -> IDLE on the next cycle and del_o=base one cycle later. Assert rst mid-DOWN -> del_o=1, cfg_rdy=1 and the active config returns to base 1, depth 0, rate 1.
